// File: rtl/uart_tx_sched.sv
// Transmit scheduler: buffers UART store bytes in a circular FIFO and launches
// one frame at a time, handshaking on the transmitter's busy signal.
module uart_tx_sched #(
  parameter int ADDR_W       = 4,
  parameter int BUSY_TIMEOUT = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [7:0]        wr_data,
  input  logic              tx_busy,
  input  logic              clr_ovf,
  output logic              tx_start,
  output logic [7:0]        tx_data,
  output logic [ADDR_W:0]   count,
  output logic              empty,
  output logic              full,
  output logic              overflow
);

  localparam int              DEPTH    = 2**ADDR_W;
  localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W+1)'(DEPTH);
  localparam logic [7:0]      TMO_LAST = 8'(BUSY_TIMEOUT-1);

  typedef enum logic [1:0] {IDLE, WAIT_BUSY, WAIT_DONE} state_t;

  state_t                  state;
  logic [DEPTH-1:0][7:0]   mem;
  logic [ADDR_W-1:0]       rd_ptr, wr_ptr;
  logic [7:0]              timer;
  logic                    pop, push, drop;

  assign empty = (count == '0);
  assign full  = (count == FULL_CNT);
  assign pop   = (state == IDLE) && !empty;
  // A full FIFO still accepts a store when the launcher frees a slot this cycle.
  assign push  = wr_en && (!full || pop);
  assign drop  = wr_en && full && !pop;

  always_ff @(posedge clk)
    if (push) mem[wr_ptr] <= wr_data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + ADDR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + (ADDR_W+1)'(1);
        2'b01:   count <= count - (ADDR_W+1)'(1);
        default: count <= count;
      endcase
      if (drop)         overflow <= 1'b1;
      else if (clr_ovf) overflow <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      tx_start <= 1'b0;
      tx_data  <= 8'h00;
      rd_ptr   <= '0;
      timer    <= 8'd0;
    end else begin
      case (state)
        IDLE: begin
          if (!empty) begin
            tx_data  <= mem[rd_ptr];
            rd_ptr   <= rd_ptr + ADDR_W'(1);
            tx_start <= 1'b1;
            timer    <= 8'd0;
            state    <= WAIT_BUSY;
          end else begin
            tx_start <= 1'b0;
          end
        end
        WAIT_BUSY: begin
          tx_start <= 1'b0;
          // A transmitter that never acknowledges still consumes the byte.
          if (tx_busy)                state <= WAIT_DONE;
          else if (timer == TMO_LAST) state <= IDLE;
          else                        timer <= timer + 8'd1;
        end
        WAIT_DONE: begin
          tx_start <= 1'b0;
          if (!tx_busy) state <= IDLE;
        end
        default: begin
          tx_start <= 1'b0;
          state    <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_sched.sv
// Bench for uart_tx_sched: table-driven cycle vectors, directed corner cases,
// and a randomized run against a queue-based reference model.
module tb_uart_tx_sched;
  localparam int ADDR_W = 4;
  localparam int DEPTH  = 16;
  localparam int TMO    = 4;
  localparam int HOLD   = 10;
  localparam logic H = 1'b1;
  localparam logic L = 1'b0;

  logic clk = 1'b0, rst_n = 1'b0, wr_en = 1'b0, tx_busy = 1'b0, clr_ovf = 1'b0;
  logic [7:0] wr_data = 8'h00;
  logic tx_start, empty, full, overflow;
  logic [7:0] tx_data;
  logic [ADDR_W:0] count;

  int total = 0, bad = 0;
  int busy_mode = 0, busy_left = 0, cyc = 0;
  logic prev_start = 1'b0;
  logic [7:0] launched[$];
  int launch_cyc[$];

  uart_tx_sched #(.ADDR_W(ADDR_W), .BUSY_TIMEOUT(TMO)) dut (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_data(wr_data), .tx_busy(tx_busy),
    .clr_ovf(clr_ovf), .tx_start(tx_start), .tx_data(tx_data), .count(count),
    .empty(empty), .full(full), .overflow(overflow));

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Launch monitor plus a transmitter model that goes busy for HOLD cycles.
  always @(negedge clk) begin
    cyc++;
    if (tx_start) begin
      chk("no_back_to_back_start", {31'd0, prev_start}, 32'd0);
      launched.push_back(tx_data);
      launch_cyc.push_back(cyc);
    end
    prev_start = tx_start;
    if (busy_mode == 1) begin
      if (tx_start) begin
        tx_busy = 1'b1;
        busy_left = HOLD;
      end else if (busy_left > 0) begin
        busy_left--;
        if (busy_left == 0) tx_busy = 1'b0;
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic wr; logic [7:0] d; logic busy; logic clr;
    logic st; logic [7:0] td; logic [4:0] cnt; logic ovf;
  } vec_t;

  function automatic vec_t mk(input logic wr, input logic [7:0] d, input logic busy,
                              input logic clr, input logic st, input logic [7:0] td,
                              input logic [4:0] cnt, input logic ovf);
    vec_t v;
    v.wr = wr; v.d = d; v.busy = busy; v.clr = clr;
    v.st = st; v.td = td; v.cnt = cnt; v.ovf = ovf;
    return v;
  endfunction

  task automatic push(input logic [7:0] d);
    wr_en = 1'b1;
    wr_data = d;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic do_reset();
    busy_mode = 0; busy_left = 0; tx_busy = 1'b0; wr_en = 1'b0; clr_ovf = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic wait_launch(input int n, input int limit);
    int k = 0;
    while (launched.size() < n && k < limit) begin
      @(negedge clk);
      k++;
    end
    chk("launch_count_within_budget", launched.size(), n);
  endtask

  task automatic chk_seq(input string nm, input logic [7:0] exp[$]);
    for (int i = 0; i < exp.size(); i++)
      chk(nm, (i < launched.size()) ? {24'd0, launched[i]} : 32'hDEAD, {24'd0, exp[i]});
  endtask

  vec_t tbl[15];
  logic [7:0] exp_q[$];
  logic [7:0] mq[$];
  int free_at, msize;
  logic m_wr, m_clr, m_pop, m_start, m_ovf;
  logic [7:0] m_d, m_data;

  initial begin
    tbl[0]  = mk(H, 8'h41, L, L,  L, 8'h00, 5'd1, L);
    tbl[1]  = mk(L, 8'h00, L, L,  H, 8'h41, 5'd0, L);
    tbl[2]  = mk(L, 8'h00, H, L,  L, 8'h41, 5'd0, L);
    tbl[3]  = mk(L, 8'h00, H, L,  L, 8'h41, 5'd0, L);
    tbl[4]  = mk(L, 8'h00, L, L,  L, 8'h41, 5'd0, L);
    tbl[5]  = mk(H, 8'h42, L, L,  L, 8'h41, 5'd1, L);
    tbl[6]  = mk(H, 8'h43, L, L,  H, 8'h42, 5'd1, L);
    tbl[7]  = mk(L, 8'h00, L, L,  L, 8'h42, 5'd1, L);
    tbl[8]  = mk(L, 8'h00, L, L,  L, 8'h42, 5'd1, L);
    tbl[9]  = mk(L, 8'h00, L, L,  L, 8'h42, 5'd1, L);
    tbl[10] = mk(L, 8'h00, L, L,  L, 8'h42, 5'd1, L);
    tbl[11] = mk(L, 8'h00, L, L,  H, 8'h43, 5'd0, L);
    tbl[12] = mk(L, 8'h00, H, L,  L, 8'h43, 5'd0, L);
    tbl[13] = mk(L, 8'h00, L, L,  L, 8'h43, 5'd0, L);
    tbl[14] = mk(L, 8'h00, L, H,  L, 8'h43, 5'd0, L);

    // Reset values, sampled while reset is still asserted
    repeat (2) @(negedge clk);
    chk("rst_tx_start", {31'd0, tx_start}, 32'd0);
    chk("rst_tx_data", {24'd0, tx_data}, 32'h00);
    chk("rst_count", {27'd0, count}, 32'd0);
    chk("rst_empty", {31'd0, empty}, 32'd1);
    chk("rst_full", {31'd0, full}, 32'd0);
    chk("rst_overflow", {31'd0, overflow}, 32'd0);
    rst_n = 1'b1;

    // Cycle-by-cycle vectors: single launch, busy handshake, timeout path
    for (int i = 0; i < 15; i++) begin
      wr_en = tbl[i].wr; wr_data = tbl[i].d; tx_busy = tbl[i].busy; clr_ovf = tbl[i].clr;
      @(negedge clk);
      chk($sformatf("vec%0d_tx_start", i), {31'd0, tx_start}, {31'd0, tbl[i].st});
      chk($sformatf("vec%0d_tx_data", i), {24'd0, tx_data}, {24'd0, tbl[i].td});
      chk($sformatf("vec%0d_count", i), {27'd0, count}, {27'd0, tbl[i].cnt});
      chk($sformatf("vec%0d_overflow", i), {31'd0, overflow}, {31'd0, tbl[i].ovf});
    end
    wr_en = 1'b0; clr_ovf = 1'b0; tx_busy = 1'b0;

    // Burst of 16 while the launcher is parked in a busy frame
    launched.delete();
    tx_busy = 1'b1;
    push(8'hEE);
    repeat (3) @(negedge clk);
    chk("burst_dummy_launch", launched.size(), 1);
    launched.delete();
    for (int i = 0; i < 16; i++) push(8'(i));
    chk("burst_full", {31'd0, full}, 32'd1);
    chk("burst_count16", {27'd0, count}, 32'd16);
    chk("burst_no_ovf", {31'd0, overflow}, 32'd0);
    tx_busy = 1'b0; busy_mode = 1;
    wait_launch(16, 800);
    exp_q.delete();
    for (int i = 0; i < 16; i++) exp_q.push_back(8'(i));
    chk_seq("burst_order", exp_q);
    repeat (20) @(negedge clk);
    chk("burst_final_count", {27'd0, count}, 32'd0);
    chk("burst_final_empty", {31'd0, empty}, 32'd1);
    chk("burst_final_ovf", {31'd0, overflow}, 32'd0);

    // Overflow and clear priority
    busy_mode = 0; tx_busy = 1'b1;
    push(8'hEE);
    repeat (3) @(negedge clk);
    launched.delete();
    for (int i = 0; i < 16; i++) push(8'h10 + 8'(i));
    chk("ovf_fill_count", {27'd0, count}, 32'd16);
    chk("ovf_fill_full", {31'd0, full}, 32'd1);
    push(8'hAA);
    chk("ovf_drop_flag", {31'd0, overflow}, 32'd1);
    chk("ovf_drop_count", {27'd0, count}, 32'd16);
    clr_ovf = 1'b1;
    @(negedge clk);
    clr_ovf = 1'b0;
    chk("ovf_cleared", {31'd0, overflow}, 32'd0);
    clr_ovf = 1'b1;
    push(8'hBB);
    clr_ovf = 1'b0;
    chk("ovf_set_beats_clear", {31'd0, overflow}, 32'd1);
    clr_ovf = 1'b1;
    @(negedge clk);
    clr_ovf = 1'b0;
    chk("ovf_cleared_again", {31'd0, overflow}, 32'd0);

    // Full FIFO, push on the same cycle as a pop
    tx_busy = 1'b0;
    @(negedge clk);
    chk("fullpop_pre_count", {27'd0, count}, 32'd16);
    push(8'h55);
    chk("fullpop_start", {31'd0, tx_start}, 32'd1);
    chk("fullpop_data", {24'd0, tx_data}, 32'h10);
    chk("fullpop_count", {27'd0, count}, 32'd16);
    chk("fullpop_no_ovf", {31'd0, overflow}, 32'd0);
    busy_mode = 1;
    wait_launch(17, 1200);
    exp_q.delete();
    for (int i = 0; i < 16; i++) exp_q.push_back(8'h10 + 8'(i));
    exp_q.push_back(8'h55);
    chk_seq("fullpop_order", exp_q);
    repeat (20) @(negedge clk);
    chk("fullpop_final_count", {27'd0, count}, 32'd0);

    // Busy timeout with pointer wrap: 20 pushes two cycles apart
    busy_mode = 0; tx_busy = 1'b0;
    launched.delete(); launch_cyc.delete();
    for (int i = 0; i < 20; i++) begin
      push(8'h60 + 8'(i));
      @(negedge clk);
    end
    wait_launch(20, 400);
    exp_q.delete();
    for (int i = 0; i < 20; i++) exp_q.push_back(8'h60 + 8'(i));
    chk_seq("tmo_order", exp_q);
    for (int i = 1; i < 20 && i < launch_cyc.size(); i++)
      chk("tmo_launch_spacing", launch_cyc[i] - launch_cyc[i-1], TMO + 1);
    repeat (8) @(negedge clk);
    chk("tmo_final_empty", {31'd0, empty}, 32'd1);

    // Randomized run: pops are possible every TMO+1 edges with busy tied low
    do_reset();
    mq.delete(); free_at = 0; m_ovf = 1'b0; m_data = 8'h00;
    for (int e = 0; e < 600; e++) begin
      m_wr  = (e < 300) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 7) == 0);
      m_clr = ($urandom_range(0, 15) == 0);
      m_d   = 8'($urandom);
      wr_en = m_wr; wr_data = m_d; clr_ovf = m_clr;
      msize = mq.size();
      m_pop = (e >= free_at) && (msize > 0);
      m_start = m_pop;
      if (m_pop) begin
        m_data = mq.pop_front();
        free_at = e + TMO + 1;
      end
      if (m_wr && (msize < DEPTH || m_pop)) mq.push_back(m_d);
      else if (m_wr) m_ovf = 1'b1;
      else if (m_clr) m_ovf = 1'b0;
      if (m_wr && !(msize < DEPTH || m_pop)) m_ovf = 1'b1;
      else if (m_clr && !m_wr) m_ovf = 1'b0;
      else if (m_clr && m_wr) m_ovf = 1'b0;
      @(negedge clk);
      chk("rnd_tx_start", {31'd0, tx_start}, {31'd0, m_start});
      chk("rnd_tx_data", {24'd0, tx_data}, {24'd0, m_data});
      chk("rnd_count", {27'd0, count}, mq.size());
      chk("rnd_empty", {31'd0, empty}, {31'd0, mq.size() == 0});
      chk("rnd_full", {31'd0, full}, {31'd0, mq.size() == DEPTH});
      chk("rnd_overflow", {31'd0, overflow}, {31'd0, m_ovf});
    end
    wr_en = 1'b0; clr_ovf = 1'b0;

    // Asynchronous reset while a launch is in flight
    do_reset();
    tx_busy = 1'b1;
    push(8'hEE);
    repeat (3) @(negedge clk);
    for (int i = 0; i < 5; i++) push(8'h70 + 8'(i));
    chk("mid_rst_pre_count", {27'd0, count}, 32'd5);
    tx_busy = 1'b0;
    @(negedge clk);
    push(8'h75);
    chk("mid_rst_pre_start", {31'd0, tx_start}, 32'd1);
    chk("mid_rst_pre_count5", {27'd0, count}, 32'd5);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_async_start", {31'd0, tx_start}, 32'd0);
    chk("mid_rst_async_count", {27'd0, count}, 32'd0);
    chk("mid_rst_async_empty", {31'd0, empty}, 32'd1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    launched.delete();
    repeat (20) @(negedge clk);
    chk("mid_rst_no_spurious_launch", launched.size(), 0);
    push(8'h99);
    wait_launch(1, 10);
    chk("mid_rst_new_launch", (launched.size() > 0) ? {24'd0, launched[0]} : 32'hDEAD, 32'h99);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
